truth_sweep_ctrl: RTL and testbench

TRUTH_SWEEP_CTRL -- requirements
Module: truth_sweep_ctrl

---
 rtl/truth_sweep_ctrl_if.sv | 29 ++
 rtl/truth_sweep_ctrl.sv | 105 ++++++++++
 tb/tb_truth_sweep_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/truth_sweep_ctrl_if.sv
// Sweep request/result bundle between a requester and truth_sweep_ctrl.
// The requester drives start/abort/expected and the evaluator's z. The controller drives operands and results.
interface truth_sweep_if;
    logic        start;
    logic        abort;
    logic [31:0] expected;
    logic        z;
    logic        y1;
    logic        y0;
    logic        x2;
    logic        x1;
    logic        x0;
    logic        busy;
    logic        done;
    logic [31:0] table_out;
    logic [5:0]  mismatch_cnt;
    logic [4:0]  first_err;
    logic        pass;

    modport master (
        output start, abort, expected, z,
        input  y1, y0, x2, x1, x0, busy, done, table_out, mismatch_cnt, first_err, pass
    );

    modport slave (
        input  start, abort, expected, z,
        output y1, y0, x2, x1, x0, busy, done, table_out, mismatch_cnt, first_err, pass
    );
endinterface

// File: rtl/truth_sweep_ctrl.sv
// Walks all 32 operand vectors through an external evaluator, holding each vector SETTLE+1 cycles.
// done is asserted 32*(SETTLE+1) edges after start is accepted. start is ignored while busy; abort wins.
module truth_sweep_ctrl #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    truth_sweep_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] SETTLE_V = 4'(SETTLE);

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [31:0] tab_q, tab_d;
    logic [5:0]  mis_q, mis_d;
    logic [4:0]  ferr_q, ferr_d;
    logic        pass_q, pass_d;
    logic        miss;

    assign miss = (bus.z != bus.expected[idx_q]);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        tab_d   = tab_q;
        mis_d   = mis_q;
        ferr_d  = ferr_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = RUN;
                    idx_d   = 5'd0;
                    cnt_d   = SETTLE_V;
                    tab_d   = '0;
                    mis_d   = '0;
                    ferr_d  = '0;
                    pass_d  = 1'b0;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    pass_d  = 1'b0;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    tab_d[idx_q] = bus.z;
                    if (miss) begin
                        mis_d = mis_q + 6'd1;
                        if (mis_q == 6'd0) begin
                            ferr_d = idx_q;
                        end
                    end
                    if (idx_q == 5'd31) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        // pass must reflect a miss on the final vector too
                        pass_d  = !miss && (mis_q == 6'd0);
                    end else begin
                        idx_d = idx_q + 5'd1;
                        cnt_d = SETTLE_V;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            tab_q   <= '0;
            mis_q   <= '0;
            ferr_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            tab_q   <= tab_d;
            mis_q   <= mis_d;
            ferr_q  <= ferr_d;
            pass_q  <= pass_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign {bus.y1, bus.y0, bus.x2, bus.x1, bus.x0} = bus.busy ? idx_q : 5'd0;
    assign bus.done         = done_q;
    assign bus.table_out    = tab_q;
    assign bus.mismatch_cnt = mis_q;
    assign bus.first_err    = ferr_q;
    assign bus.pass         = pass_q;
endmodule

// File: tb/tb_truth_sweep_ctrl.sv
// Drives three controllers (SETTLE 2, 0, 1) with shared stimulus and checks them against a sweep-level model.
module tb_truth_sweep_ctrl;
    localparam int NDUT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [31:0] expected;
    logic [31:0] rtab;
    int          zmode;

    logic [NDUT-1:0] obs_busy;
    logic [NDUT-1:0] obs_done;
    logic [NDUT-1:0] obs_pass;
    logic [4:0]      obs_op   [NDUT];
    logic [31:0]     obs_tab  [NDUT];
    logic [5:0]      obs_mis  [NDUT];
    logic [4:0]      obs_ferr [NDUT];

    int n_chk = 0;
    int n_fail = 0;
    int edge_n;
    int done_cnt [NDUT];
    int done_edge [NDUT];
    int fall_edge [NDUT];

    logic [31:0] m_tab  [NDUT];
    int          m_mis  [NDUT];
    int          m_ferr [NDUT];
    bit          m_pass [NDUT];
    int          m_done [NDUT];
    int          m_fall [NDUT];

    always #5 clk = ~clk;

    // External evaluator: 0 -> z = x0, 1 -> z = 0, otherwise lookup in rtab.
    function automatic logic zf(int m, logic [31:0] t, logic [4:0] i);
        case (m)
            0:       return i[0];
            1:       return 1'b0;
            default: return t[i];
        endcase
    endfunction

    function automatic int settle_of(int k);
        return (k == 0) ? 2 : (k == 1) ? 0 : 1;
    endfunction

    for (genvar k = 0; k < NDUT; k++) begin : g
        localparam int unsigned S = (k == 0) ? 2 : (k == 1) ? 0 : 1;
        truth_sweep_if bus ();
        assign bus.start    = start;
        assign bus.abort    = abort;
        assign bus.expected = expected;
        assign bus.z        = zf(zmode, rtab, {bus.y1, bus.y0, bus.x2, bus.x1, bus.x0});
        truth_sweep_ctrl #(.SETTLE(S)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
        assign obs_busy[k] = bus.busy;
        assign obs_done[k] = bus.done;
        assign obs_pass[k] = bus.pass;
        assign obs_op[k]   = {bus.y1, bus.y0, bus.x2, bus.x1, bus.x0};
        assign obs_tab[k]  = bus.table_out;
        assign obs_mis[k]  = bus.mismatch_cnt;
        assign obs_ferr[k] = bus.first_err;
    end

    task automatic chk(string tag, int k, logic [63:0] obs, logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic tick();
        logic [NDUT-1:0] prev;
        prev = obs_busy;
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            if (obs_done[k] === 1'b1) begin
                done_cnt[k]++;
                done_edge[k] = edge_n;
            end
            if (prev[k] && !obs_busy[k]) fall_edge[k] = edge_n;
        end
    endtask

    // Outcome of a whole sweep: which vectors get sampled, and the resulting counts.
    task automatic model(int ab);
        for (int k = 0; k < NDUT; k++) begin
            int s, len, c, mis, ferr;
            bit aborted, found;
            logic [31:0] t;
            s       = settle_of(k);
            len     = 32 * (s + 1);
            aborted = (ab >= 1) && (ab <= len);
            c       = aborted ? (ab - 1) / (s + 1) : 32;
            t = '0; mis = 0; ferr = 0; found = 0;
            for (int i = 0; i < c; i++) begin
                t[i] = zf(zmode, rtab, 5'(i));
                if (t[i] != expected[i]) begin
                    mis++;
                    if (!found) begin
                        ferr  = i;
                        found = 1;
                    end
                end
            end
            m_tab[k]  = t;
            m_mis[k]  = mis;
            m_ferr[k] = ferr;
            m_pass[k] = !aborted && (mis == 0);
            m_done[k] = aborted ? 0 : 1;
            m_fall[k] = aborted ? ab : len;
        end
    endtask

    task automatic check_results(bit timing);
        for (int k = 0; k < NDUT; k++) begin
            chk("idle_busy", k, 64'(obs_busy[k]), 64'd0);
            chk("idle_operands", k, 64'(obs_op[k]), 64'd0);
            chk("table_out", k, 64'(obs_tab[k]), 64'(m_tab[k]));
            chk("mismatch_cnt", k, 64'(obs_mis[k]), 64'(m_mis[k]));
            if (m_mis[k] != 0) chk("first_err", k, 64'(obs_ferr[k]), 64'(m_ferr[k]));
            chk("pass", k, 64'(obs_pass[k]), 64'(m_pass[k]));
            if (timing) begin
                chk("done_pulses", k, 64'(done_cnt[k]), 64'(m_done[k]));
                if (m_done[k] != 0) chk("done_edge", k, 64'(done_edge[k]), 64'(32 * (settle_of(k) + 1)));
                chk("busy_fall_edge", k, 64'(fall_edge[k]), 64'(m_fall[k]));
            end
        end
    endtask

    // Start a sweep on the next edge, optionally re-pulse start or abort at given edges, run to idle.
    task automatic run(int p1, int p2, int ab);
        int guard;
        model(ab);
        for (int k = 0; k < NDUT; k++) begin
            done_cnt[k] = 0; done_edge[k] = -1; fall_edge[k] = -1;
        end
        start  = 1'b1;
        edge_n = -1;
        tick();
        start = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            chk("busy_after_start", k, 64'(obs_busy[k]), 64'd1);
            chk("cleared_table", k, 64'(obs_tab[k]), 64'd0);
            chk("cleared_mismatch", k, 64'(obs_mis[k]), 64'd0);
            chk("cleared_first_err", k, 64'(obs_ferr[k]), 64'd0);
            chk("cleared_pass", k, 64'(obs_pass[k]), 64'd0);
        end
        guard = 0;
        while (obs_busy != '0 && guard < 400) begin
            start = (edge_n + 1 == p1) || (edge_n + 1 == p2);
            abort = (edge_n + 1 == ab);
            tick();
            guard++;
        end
        start = 1'b0;
        abort = 1'b0;
        check_results(1'b1);
    endtask

    task automatic check_zero(string tag);
        for (int k = 0; k < NDUT; k++) begin
            chk({tag, "_busy"}, k, 64'(obs_busy[k]), 64'd0);
            chk({tag, "_done"}, k, 64'(obs_done[k]), 64'd0);
            chk({tag, "_operands"}, k, 64'(obs_op[k]), 64'd0);
            chk({tag, "_table"}, k, 64'(obs_tab[k]), 64'd0);
            chk({tag, "_mismatch"}, k, 64'(obs_mis[k]), 64'd0);
            chk({tag, "_first_err"}, k, 64'(obs_ferr[k]), 64'd0);
            chk({tag, "_pass"}, k, 64'(obs_pass[k]), 64'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        zmode = 0; rtab = '0; expected = '0; edge_n = 0;
        for (int k = 0; k < NDUT; k++) begin
            done_cnt[k] = 0; done_edge[k] = -1; fall_edge[k] = -1;
        end
        @(negedge clk);
        tick();
        tick();
        check_zero("reset");
        rst_n = 1'b1;
        tick();

        // Clean sweep: z follows x0, golden table matches.
        zmode = 0; expected = 32'hAAAA_AAAA;
        run(-1, -1, -1);

        // Constant-zero evaluator against a table with two ones.
        zmode = 1; expected = 32'h8000_0010;
        run(-1, -1, -1);

        // Results stay put while idle even as inputs wander.
        zmode = 2; rtab = $urandom; expected = $urandom;
        repeat (4) tick();
        check_results(1'b0);

        // start re-pulsed mid-sweep is ignored.
        rtab = $urandom; expected = $urandom;
        run(5, 20, -1);

        // Abort while the SETTLE=1 controller presents vector 10.
        zmode = 0; expected = $urandom;
        run(-1, -1, 21);

        // start together with abort in idle is refused.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check_results(1'b0);
        zmode = 2; rtab = $urandom; expected = $urandom;
        run(-1, -1, -1);

        // Reset in the middle of a sweep, then start on the first released edge.
        start = 1'b1; edge_n = -1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        chk("operands_before_reset", 1, 64'(obs_op[1]), 64'd7);
        for (int k = 0; k < NDUT; k++) done_cnt[k] = 0;
        rst_n = 1'b0;
        tick();
        check_zero("mid_reset");
        tick();
        check_zero("mid_reset2");
        for (int k = 0; k < NDUT; k++) chk("no_done_in_reset", k, 64'(done_cnt[k]), 64'd0);
        rst_n = 1'b1;
        run(-1, -1, -1);

        // Back-to-back random sweeps, including a lone miss on vector 31.
        for (int it = 0; it < 4; it++) begin
            zmode = 2;
            rtab  = $urandom;
            case (it)
                0:       expected = rtab;
                1:       expected = rtab ^ 32'h8000_0000;
                2:       expected = $urandom;
                default: expected = rtab ^ ($urandom & $urandom & $urandom);
            endcase
            run(-1, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
